// File: rtl/csa_pkg.sv
// Shared width helpers and FSM state type for the carry-save resolver.
// Widths derive from the operand parameters so every file agrees on them.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int calc_n(int size, int size_bi, int size_log);
        return size + size_bi + size_log + 2;
    endfunction

    function automatic int calc_r(int n);
        return n + 2;
    endfunction

    function automatic int calc_k(int r, int chunk);
        return (r + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/csa_resolver_if.sv
// Request/response bundle between a producer of carry-save pairs
// and the resolver that returns their binary sum.
interface csa_resolver_if
    import csa_pkg::*;
#(
    parameter int N = calc_n(3072, 72, 6),
    parameter int R = calc_r(N)
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] s_in;
    logic [N-1:0] c_in;
    logic         out_valid;
    logic         out_ready;
    logic [R-1:0] sum_out;

    modport master (
        output in_valid, s_in, c_in, out_ready,
        input  in_ready, out_valid, sum_out
    );

    modport slave (
        input  in_valid, s_in, c_in, out_ready,
        output in_ready, out_valid, sum_out
    );
endinterface

// File: rtl/chunk_adder.sv
// One slice of the multi-cycle carry-propagate adder.
// Pure combinational ripple add with carry in and carry out.
module chunk_adder #(
    parameter int Chunk = 64
) (
    input  logic [Chunk-1:0] a,
    input  logic [Chunk-1:0] b,
    input  logic             cin,
    output logic [Chunk-1:0] s,
    output logic             cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + (Chunk + 1)'(cin);
endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair (s + 2c) into binary, one Chunk-wide
// slice per cycle, behind a valid/ready handshake on both sides.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int Size     = 3072,
    parameter int Size_bi  = 72,
    parameter int Size_log = 6,
    parameter int Chunk    = 64
) (
    input logic         clk,
    input logic         rst,
    csa_resolver_if.slave bus
);
    localparam int N  = calc_n(Size, Size_bi, Size_log);
    localparam int R  = calc_r(N);
    localparam int K  = calc_k(R, Chunk);
    localparam int W  = K * Chunk;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    state_t state_q, state_d;

    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     res_q;
    logic [Chunk-1:0] slice_s;
    logic             slice_c;
    logic             in_ready;
    logic             out_valid;

    chunk_adder #(
        .Chunk(Chunk)
    ) u_add (
        .a   (a_q[Chunk-1:0]),
        .b   (b_q[Chunk-1:0]),
        .cin (carry_q),
        .s   (slice_s),
        .cout(slice_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                if (idx_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands shift down one slice per cycle; finished slices enter the
    // result from the top, so after K cycles slice i sits at position i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else if (state_q == IDLE) begin
            if (bus.in_valid) begin
                a_q     <= W'(bus.s_in);
                b_q     <= W'({bus.c_in, 1'b0});
                carry_q <= 1'b0;
                idx_q   <= '0;
            end
        end else if (state_q == RUN) begin
            a_q     <= a_q >> Chunk;
            b_q     <= b_q >> Chunk;
            res_q   <= W'({slice_s, res_q} >> Chunk);
            carry_q <= slice_c;
            idx_q   <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum_out   = res_q[R-1:0];

endmodule
